// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
package mem_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int INSTR_W    = 32;
  localparam int REG_IDX_W  = 5;
  localparam int DEST_SRC_W = 2;
  localparam int MEM_OP_W   = 4;
  localparam int BE_W       = WORD_W / 8;

  typedef enum logic [MEM_OP_W-1:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LH   = 4'd2,
    MEM_OP_LW   = 4'd3,
    MEM_OP_LBU  = 4'd4,
    MEM_OP_LHU  = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [DEST_SRC_W-1:0] {
    DEST_SRC_NONE = 2'd0,
    DEST_SRC_ALU  = 2'd1,
    DEST_SRC_MEM  = 2'd2,
    DEST_SRC_PC   = 2'd3
  } dest_src_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic is_mem_op(mem_op_e op);
    return (op inside {MEM_OP_LB, MEM_OP_LH, MEM_OP_LW, MEM_OP_LBU, MEM_OP_LHU,
                       MEM_OP_SB, MEM_OP_SH, MEM_OP_SW});
  endfunction

  function automatic logic is_store(mem_op_e op);
    return (op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW});
  endfunction

  function automatic logic is_misaligned(mem_op_e op, logic [1:0] addr_lo);
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return addr_lo[0];
      MEM_OP_LW, MEM_OP_SW:             return (addr_lo != 2'b00);
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_if.sv
// Data-memory request/acknowledge bus between the stage and data memory.
interface mem_if;
  import mem_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic              ack;
  logic [WORD_W-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_align.sv
// Byte-lane steering: store replication/byte enables and load extraction/extension.
module mem_align
  import mem_pkg::*;
(
  input  mem_op_e           op,
  input  logic [1:0]        addr_lo,
  input  logic [WORD_W-1:0] store_data,
  input  logic [WORD_W-1:0] rdata,
  output logic [WORD_W-1:0] wdata,
  output logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    wdata = store_data;
    be    = {BE_W{1'b0}};
    case (op)
      MEM_OP_SB: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      MEM_OP_SH: begin
        wdata = {2{store_data[15:0]}};
        be    = 4'b0011 << addr_lo;
      end
      MEM_OP_SW: begin
        wdata = store_data;
        be    = 4'b1111;
      end
      default: begin
        wdata = store_data;
        be    = {BE_W{1'b0}};
      end
    endcase
  end

  always_comb begin
    load_data = {WORD_W{1'b0}};
    case (op)
      MEM_OP_LB:  load_data = {{(WORD_W-8){byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: load_data = {{(WORD_W-8){1'b0}}, byte_sel};
      MEM_OP_LH:  load_data = {{(WORD_W-16){half_sel[15]}}, half_sel};
      MEM_OP_LHU: load_data = {{(WORD_W-16){1'b0}}, half_sel};
      MEM_OP_LW:  load_data = rdata;
      default:    load_data = {WORD_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/mem.sv
// Memory-access pipeline stage: registers execute results, runs the data-memory
// handshake and presents the write-back value.
module mem
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  stall,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [INSTR_W-1:0]    i_instr,
  input  logic [MEM_OP_W-1:0]   i_mem_op,
  input  logic [WORD_W-1:0]     i_alu_eval,
  input  logic [WORD_W-1:0]     i_store_data,
  input  logic [DEST_SRC_W-1:0] i_dest_src,
  input  logic [REG_IDX_W-1:0]  i_dest_reg,
  output logic [ADDR_W-1:0]     o_pc,
  output logic [INSTR_W-1:0]    o_instr,
  output logic [DEST_SRC_W-1:0] o_dest_src,
  output logic [REG_IDX_W-1:0]  o_dest_reg,
  output logic [WORD_W-1:0]     o_wb_data,
  output logic                  o_misalign,
  output logic                  o_stall,
  mem_if.master                 dmem
);

  state_e               state, state_nxt;
  mem_op_e              in_op;
  logic                 capture;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_instr;
  mem_op_e              r_mem_op;
  logic [WORD_W-1:0]    r_alu_eval;
  logic [WORD_W-1:0]    r_store_data;
  dest_src_e            r_dest_src;
  logic [REG_IDX_W-1:0] r_dest_reg;
  logic [WORD_W-1:0]    r_rdata;
  logic [WORD_W-1:0]    align_wdata;
  logic [BE_W-1:0]      align_be;
  logic [WORD_W-1:0]    load_data;

  assign in_op   = mem_op_e'(i_mem_op);
  assign o_stall = (state == ST_ACCESS) | stall;
  assign capture = ~o_stall;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (capture)
          state_nxt = (is_mem_op(in_op) && !is_misaligned(in_op, i_alu_eval[1:0]))
                      ? ST_ACCESS : ST_IDLE;
        else
          state_nxt = state;
      end
      ST_ACCESS: begin
        if (dmem.ack) state_nxt = ST_DONE;
        else          state_nxt = ST_ACCESS;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_pc         <= {ADDR_W{1'b0}};
      r_instr      <= {INSTR_W{1'b0}};
      r_mem_op     <= MEM_OP_NONE;
      r_alu_eval   <= {WORD_W{1'b0}};
      r_store_data <= {WORD_W{1'b0}};
      r_dest_src   <= DEST_SRC_NONE;
      r_dest_reg   <= {REG_IDX_W{1'b0}};
    end else if (capture) begin
      r_pc         <= i_pc;
      r_instr      <= i_instr;
      r_mem_op     <= in_op;
      r_alu_eval   <= i_alu_eval;
      r_store_data <= i_store_data;
      r_dest_src   <= dest_src_e'(i_dest_src);
      r_dest_reg   <= i_dest_reg;
    end
  end

  // Load data is only taken on an ack that completes a live request.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                                   r_rdata <= {WORD_W{1'b0}};
    else if ((state == ST_ACCESS) && dmem.ack) r_rdata <= dmem.rdata;
  end

  mem_align u_align (
    .op         (r_mem_op),
    .addr_lo    (r_alu_eval[1:0]),
    .store_data (r_store_data),
    .rdata      (r_rdata),
    .wdata      (align_wdata),
    .be         (align_be),
    .load_data  (load_data)
  );

  assign dmem.req   = (state == ST_ACCESS);
  assign dmem.we    = dmem.req & is_store(r_mem_op);
  assign dmem.addr  = {r_alu_eval[ADDR_W-1:2], 2'b00};
  assign dmem.wdata = align_wdata;
  assign dmem.be    = dmem.req ? align_be : {BE_W{1'b0}};

  assign o_misalign = is_misaligned(r_mem_op, r_alu_eval[1:0]);
  assign o_dest_src = ((state == ST_ACCESS) || o_misalign) ? DEST_SRC_NONE : r_dest_src;
  assign o_wb_data  = (r_dest_src == DEST_SRC_MEM) ? load_data : r_alu_eval;
  assign o_pc       = r_pc;
  assign o_instr    = r_instr;
  assign o_dest_reg = r_dest_reg;

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for mem: directed scenarios plus randomized traffic
// against a transaction-level model of the stage occupant.
module tb_mem;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        clr, stall;
  logic [31:0] i_pc, i_instr, i_alu_eval, i_store_data;
  logic [3:0]  i_mem_op;
  logic [1:0]  i_dest_src;
  logic [4:0]  i_dest_reg;
  logic [31:0] o_pc, o_instr, o_wb_data;
  logic [1:0]  o_dest_src;
  logic [4:0]  o_dest_reg;
  logic        o_misalign, o_stall;

  int checks   = 0;
  int failures = 0;

  mem_if dmem ();

  mem dut (
    .clk(clk), .clr(clr), .stall(stall),
    .i_pc(i_pc), .i_instr(i_instr), .i_mem_op(i_mem_op), .i_alu_eval(i_alu_eval),
    .i_store_data(i_store_data), .i_dest_src(i_dest_src), .i_dest_reg(i_dest_reg),
    .o_pc(o_pc), .o_instr(o_instr), .o_dest_src(o_dest_src), .o_dest_reg(o_dest_reg),
    .o_wb_data(o_wb_data), .o_misalign(o_misalign), .o_stall(o_stall),
    .dmem(dmem)
  );

  always #5 clk = ~clk;

  // Model: the instruction currently occupying the stage and whether its access completed.
  typedef struct {
    logic [31:0] pc, instr, alu, sd, rdata;
    int          op, dest;
    logic [4:0]  rg;
    bit          acked;
  } occ_t;
  occ_t m;

  function automatic int op_size(int op);
    case (op)
      1, 4, 6: return 1;
      2, 5, 7: return 2;
      3, 8:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_misal();
    int sz = op_size(m.op);
    return (sz > 0) && ((int'(m.alu[1:0]) % sz) != 0);
  endfunction

  function automatic bit m_pending();
    return (op_size(m.op) > 0) && !m_misal() && !m.acked;
  endfunction

  function automatic bit m_store();
    return (m.op >= 6) && (m.op <= 8);
  endfunction

  function automatic logic [31:0] m_load();
    int          lo = int'(m.alu[1:0]);
    logic [31:0] w  = m.rdata >> (8 * lo);
    int          v;
    case (m.op)
      1: begin v = int'(w & 32'hFF);   if (v >= 128)   v -= 256;   end
      4: v = int'(w & 32'hFF);
      2: begin v = int'(w & 32'hFFFF); if (v >= 32768) v -= 65536; end
      5: v = int'(w & 32'hFFFF);
      3: v = int'(m.rdata);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic model_reset();
    m = '{pc: 32'd0, instr: 32'd0, alu: 32'd0, sd: 32'd0, rdata: 32'd0,
          op: 0, dest: 0, rg: 5'd0, acked: 1'b0};
  endtask

  task automatic model_update();
    bit pend;
    if (clr) begin
      model_reset();
    end else begin
      pend = m_pending();
      if (!(pend || stall)) begin
        m.pc = i_pc; m.instr = i_instr; m.op = int'(i_mem_op); m.alu = i_alu_eval;
        m.sd = i_store_data; m.dest = int'(i_dest_src); m.rg = i_dest_reg; m.acked = 1'b0;
      end else if (pend && dmem.ack) begin
        m.acked = 1'b1;
        m.rdata = dmem.rdata;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    bit          pend = m_pending();
    bit          mis  = m_misal();
    int          lo   = int'(m.alu[1:0]);
    int          edst = (pend || mis) ? 0 : m.dest;
    logic [3:0]  ebe;
    chk("o_stall", 32'(o_stall), 32'(pend | stall));
    chk("req", 32'(dmem.req), 32'(pend));
    chk("misalign", 32'(o_misalign), 32'(mis));
    chk("dest_src", 32'(o_dest_src), 32'(edst));
    chk("pc", o_pc, m.pc);
    chk("instr", o_instr, m.instr);
    chk("dest_reg", 32'(o_dest_reg), 32'(m.rg));
    if (pend) begin
      ebe = m_store() ? 4'(((1 << op_size(m.op)) - 1) << lo) : 4'd0;
      chk("we", 32'(dmem.we), 32'(m_store()));
      chk("addr", dmem.addr, m.alu & 32'hFFFF_FFFC);
      chk("be", 32'(dmem.be), 32'(ebe));
      for (int i = 0; i < 4; i++)
        if (ebe[i]) chk("wdata_lane", 32'(dmem.wdata[8*i +: 8]), (m.sd >> (8 * (i - lo))) & 32'hFF);
    end else begin
      chk("we_idle", 32'(dmem.we), 32'd0);
      chk("be_idle", 32'(dmem.be), 32'd0);
    end
    if (edst != 0) chk("wb_data", o_wb_data, (m.dest == 2) ? m_load() : m.alu);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_in(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [1:0] dest);
    i_mem_op = op; i_alu_eval = alu; i_store_data = sd; i_dest_src = dest;
    i_pc = $urandom; i_instr = $urandom; i_dest_reg = 5'($urandom);
  endtask

  int          stalls;
  logic [31:0] exp_t2 [2];
  int          r_op, r_dest;

  initial begin
    exp_t2[0] = 32'hFFFF_FF80;
    exp_t2[1] = 32'h0000_0080;
    clr = 1'b1; stall = 1'b0; dmem.ack = 1'b0; dmem.rdata = 32'd0;
    set_in(MEM_OP_NONE, 32'd0, 32'd0, DEST_SRC_NONE);
    model_reset();
    @(negedge clk); @(negedge clk);
    compare_all();
    chk("rst_req", 32'(dmem.req), 32'd0);
    chk("rst_we", 32'(dmem.we), 32'd0);
    chk("rst_be", 32'(dmem.be), 32'd0);
    chk("rst_misalign", 32'(o_misalign), 32'd0);
    chk("rst_wb", o_wb_data, 32'd0);
    chk("rst_dest", 32'(o_dest_src), 32'd0);
    clr = 1'b0;

    // ALU pass-through
    set_in(MEM_OP_NONE, 32'h1234, 32'd0, DEST_SRC_ALU);
    step();
    chk("t1_wb", o_wb_data, 32'h1234);
    chk("t1_dest", 32'(o_dest_src), 32'd1);
    chk("t1_req", 32'(dmem.req), 32'd0);

    // LB / LBU at 0x103 with ack on the third request cycle
    for (int t = 0; t < 2; t++) begin
      set_in((t == 0) ? MEM_OP_LB : MEM_OP_LBU, 32'h103, 32'd0, DEST_SRC_MEM);
      step();
      chk("t2_addr", dmem.addr, 32'h100);
      chk("t2_be", 32'(dmem.be), 32'd0);
      chk("t2_we", 32'(dmem.we), 32'd0);
      set_in(MEM_OP_NONE, 32'h5555, 32'd0, DEST_SRC_ALU);
      stalls = 0;
      for (int i = 1; i <= 3; i++) begin
        if (o_stall) stalls++;
        dmem.ack = (i == 3);
        dmem.rdata = 32'h80FF_FFFF;
        step();
      end
      dmem.ack = 1'b0;
      chk("t2_stall_cycles", 32'(stalls), 32'd3);
      chk("t2_wb", o_wb_data, exp_t2[t]);
      chk("t2_dest", 32'(o_dest_src), 32'd2);
      chk("t2_stall_done", 32'(o_stall), 32'd0);
    end

    // SH at 0x22
    set_in(MEM_OP_SH, 32'h22, 32'hABCD_1234, DEST_SRC_NONE);
    step();
    chk("t3_req", 32'(dmem.req), 32'd1);
    chk("t3_we", 32'(dmem.we), 32'd1);
    chk("t3_be", 32'(dmem.be), 32'hC);
    chk("t3_wdata", dmem.wdata, 32'h1234_1234);
    chk("t3_dest", 32'(o_dest_src), 32'd0);
    dmem.ack = 1'b1;
    set_in(MEM_OP_NONE, 32'd0, 32'd0, DEST_SRC_NONE);
    step();
    dmem.ack = 1'b0;

    // misaligned LW
    set_in(MEM_OP_LW, 32'h41, 32'd0, DEST_SRC_MEM);
    step();
    chk("t4_misalign", 32'(o_misalign), 32'd1);
    chk("t4_req", 32'(dmem.req), 32'd0);
    chk("t4_dest", 32'(o_dest_src), 32'd0);
    chk("t4_stall", 32'(o_stall), 32'd0);

    // clr mid-access, then a stray ack while idle
    set_in(MEM_OP_LW, 32'h40, 32'd0, DEST_SRC_MEM);
    step();
    chk("t5_req_before", 32'(dmem.req), 32'd1);
    #2 clr = 1'b1;
    #1 chk("t5_req_async", 32'(dmem.req), 32'd0);
    stall = 1'b1; dmem.ack = 1'b1; dmem.rdata = 32'hDEAD_BEEF;
    set_in(MEM_OP_NONE, 32'h999, 32'd0, DEST_SRC_ALU);
    step();
    clr = 1'b0;
    step();
    chk("t5_req", 32'(dmem.req), 32'd0);
    chk("t5_wb", o_wb_data, 32'd0);
    chk("t5_dest", 32'(o_dest_src), 32'd0);
    dmem.ack = 1'b0; stall = 1'b0;

    // downstream stall holding DONE
    set_in(MEM_OP_LW, 32'h80, 32'd0, DEST_SRC_MEM);
    step();
    dmem.ack = 1'b1; dmem.rdata = 32'hCAFE_F00D; stall = 1'b1;
    set_in(MEM_OP_NONE, 32'h77, 32'd0, DEST_SRC_ALU);
    step();
    dmem.ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t6_wb_hold", o_wb_data, 32'hCAFE_F00D);
      chk("t6_dest_hold", 32'(o_dest_src), 32'd2);
      chk("t6_stall", 32'(o_stall), 32'd1);
      if (i == 0) step();
    end
    stall = 1'b0;
    step();
    chk("t6_wb_next", o_wb_data, 32'h77);
    chk("t6_dest_next", 32'(o_dest_src), 32'd1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      stall = ($urandom_range(0, 9) < 2);
      if (m_pending()) dmem.ack = ($urandom_range(0, 2) == 0);
      else             dmem.ack = ($urandom_range(0, 9) == 0);
      dmem.rdata = $urandom;
      r_op = int'($urandom_range(0, 8));
      if (r_op >= 6)      r_dest = 0;
      else if (r_op >= 1) r_dest = 2;
      else begin
        r_dest = int'($urandom_range(0, 2));
        if (r_dest == 2) r_dest = 3;
      end
      set_in(4'(r_op), $urandom, $urandom, 2'(r_dest));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
